// File: rtl/cc_pattern_driver.sv
// Stimulus sequencer and score checker for the CC core: serialises one packed pattern
// record into CC's load/action protocol, scores the result and flags protocol abuse.

module cc_pattern_driver #(
   parameter int GAP_CYC  = 2,
   parameter int TIMEOUT  = 500,
   parameter int COOL_CYC = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pat_valid,
   output logic         pat_ready,
   input  logic [222:0] pat_data,
   output logic         in_valid_1,
   output logic         in_valid_2,
   output logic [2:0]   in_color,
   output logic [5:0]   in_starting_pos,
   output logic         in_stripe,
   output logic [1:0]   in_action,
   input  logic         out_valid,
   input  logic [6:0]   out_score,
   output logic         res_valid,
   output logic         res_pass,
   output logic         res_timeout,
   output logic [6:0]   res_score,
   output logic [7:0]   pass_cnt,
   output logic [7:0]   fail_cnt,
   output logic         proto_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_GAP, S_ACT, S_WAIT, S_DONE, S_COOL
   } state_t;

   // Entry 0 of every field sits in the MSBs, so entry k is array element (N-1-k).
   typedef struct packed {
      logic [35:0][2:0] colour;
      logic [3:0][2:0]  st_row;
      logic [3:0][2:0]  st_col;
      logic [3:0]       st_type;
      logic [9:0][2:0]  act_row;
      logic [9:0][2:0]  act_col;
      logic [9:0][1:0]  action;
      logic [6:0]       exp_score;
   } pat_t;

   state_t     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   pat_t       pat_q, pat_cur;
   logic       accept;
   logic       ov_q;
   logic [5:0] li;
   logic [1:0] si;
   logic [3:0] aj;

   logic       pat_ready_d, iv1_d, iv2_d, stripe_d, res_valid_d, res_pass_d, res_timeout_d, proto_d;
   logic [2:0] color_d;
   logic [5:0] pos_d;
   logic [1:0] action_d;
   logic [6:0] res_score_d;
   logic [7:0] pass_cnt_d, fail_cnt_d;

   // NOTE: every signal assigned in this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 10'd1;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (pat_valid && pat_ready) begin
               accept  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: if (cnt_q == 10'd35) begin
            state_d = S_GAP;
            cnt_d   = '0;
         end
         S_GAP: if (cnt_q == 10'(GAP_CYC - 1)) begin
            state_d = S_ACT;
            cnt_d   = '0;
         end
         S_ACT: if (cnt_q == 10'd9) begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: if (out_valid || cnt_q == 10'(TIMEOUT - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
         end
         S_DONE: begin
            state_d = S_COOL;
            cnt_d   = '0;
         end
         S_COOL: if (cnt_q == 10'(COOL_CYC - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered from the next state, so the first load beat must come
      // straight from pat_data on the accepting edge.
      pat_cur = accept ? pat_t'(pat_data) : pat_q;
      li      = 6'd35 - cnt_d[5:0];
      si      = 2'd3 - cnt_d[1:0];
      aj      = 4'd9 - cnt_d[3:0];

      iv1_d    = 1'b0;
      iv2_d    = 1'b0;
      color_d  = '0;
      pos_d    = '0;
      stripe_d = 1'b0;
      action_d = '0;
      case (state_d)
         S_LOAD: begin
            iv1_d   = 1'b1;
            color_d = pat_cur.colour[li];
            if (cnt_d < 10'd4) begin
               pos_d    = {pat_cur.st_row[si], pat_cur.st_col[si]};
               stripe_d = pat_cur.st_type[si];
            end
         end
         S_ACT: begin
            iv2_d    = 1'b1;
            pos_d    = {pat_cur.act_row[aj], pat_cur.act_col[aj]};
            action_d = pat_cur.action[aj];
         end
         default: ;
      endcase

      pat_ready_d   = (state_d == S_IDLE);
      res_valid_d   = (state_d == S_DONE);
      res_pass_d    = res_pass;
      res_timeout_d = res_timeout;
      res_score_d   = res_score;
      pass_cnt_d    = pass_cnt;
      fail_cnt_d    = fail_cnt;
      if (state_d == S_DONE) begin
         res_timeout_d = !out_valid;
         res_score_d   = out_valid ? out_score : 7'd0;
         res_pass_d    = out_valid && (out_score == pat_q.exp_score);
         if (res_pass_d) pass_cnt_d = (pass_cnt == 8'hFF) ? pass_cnt : pass_cnt + 8'd1;
         else            fail_cnt_d = (fail_cnt == 8'hFF) ? fail_cnt : fail_cnt + 8'd1;
      end

      proto_d = proto_err
              | (out_valid && (state_q inside {S_LOAD, S_GAP, S_ACT, S_COOL}))
              | (out_valid && ov_q)
              | (!out_valid && (out_score != 7'd0));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         ov_q            <= 1'b0;
         pat_ready       <= 1'b1;
         in_valid_1      <= 1'b0;
         in_valid_2      <= 1'b0;
         in_color        <= '0;
         in_starting_pos <= '0;
         in_stripe       <= 1'b0;
         in_action       <= '0;
         res_valid       <= 1'b0;
         res_pass        <= 1'b0;
         res_timeout     <= 1'b0;
         res_score       <= '0;
         pass_cnt        <= '0;
         fail_cnt        <= '0;
         proto_err       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         ov_q            <= out_valid;
         pat_ready       <= pat_ready_d;
         in_valid_1      <= iv1_d;
         in_valid_2      <= iv2_d;
         in_color        <= color_d;
         in_starting_pos <= pos_d;
         in_stripe       <= stripe_d;
         in_action       <= action_d;
         res_valid       <= res_valid_d;
         res_pass        <= res_pass_d;
         res_timeout     <= res_timeout_d;
         res_score       <= res_score_d;
         pass_cnt        <= pass_cnt_d;
         fail_cnt        <= fail_cnt_d;
         proto_err       <= proto_d;
      end
   end

   // NOTE: the pattern register is pure data qualified by the FSM, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) pat_q <= pat_t'(pat_data);
   end

endmodule

// File: tb/tb_cc_pattern_driver.sv
// Self-checking bench for cc_pattern_driver: a cycle-window model of the expected
// outputs checked every cycle, plus hand-computed literal checks per scenario.

module tb_cc_pattern_driver;

   localparam int GAP_CYC  = 2;
   localparam int TIMEOUT  = 500;
   localparam int COOL_CYC = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         pat_valid = 1'b0;
   logic         pat_ready;
   logic [222:0] pat_data = '0;
   logic         in_valid_1, in_valid_2, in_stripe;
   logic [2:0]   in_color;
   logic [5:0]   in_starting_pos;
   logic [1:0]   in_action;
   logic         out_valid = 1'b0;
   logic [6:0]   out_score = '0;
   logic         res_valid, res_pass, res_timeout, proto_err;
   logic [6:0]   res_score;
   logic [7:0]   pass_cnt, fail_cnt;

   cc_pattern_driver #(.GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT), .COOL_CYC(COOL_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .pat_valid(pat_valid), .pat_ready(pat_ready),
      .pat_data(pat_data), .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
      .in_color(in_color), .in_starting_pos(in_starting_pos), .in_stripe(in_stripe),
      .in_action(in_action), .out_valid(out_valid), .out_score(out_score),
      .res_valid(res_valid), .res_pass(res_pass), .res_timeout(res_timeout),
      .res_score(res_score), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // Pattern source fields, as the record's author thinks of them.
   logic [2:0] s_col[36];
   logic [2:0] s_srow[4], s_scol[4];
   logic       s_stype[4];
   logic [2:0] s_arow[10], s_acol[10];
   logic [1:0] s_act[10];
   logic [6:0] s_exp;

   function automatic logic [222:0] pack();
      logic [222:0] v = '0;
      for (int i = 0; i < 36; i++) v |= 223'(s_col[i]) << (220 - 3 * i);
      for (int i = 0; i < 4; i++) begin
         v |= 223'(s_srow[i]) << (112 - 3 * i);
         v |= 223'(s_scol[i]) << (100 - 3 * i);
         v[90 - i] = s_stype[i];
      end
      for (int j = 0; j < 10; j++) begin
         v |= 223'(s_arow[j]) << (84 - 3 * j);
         v |= 223'(s_acol[j]) << (54 - 3 * j);
         v |= 223'(s_act[j]) << (25 - 2 * j);
      end
      v[6:0] = s_exp;
      return v;
   endfunction

   // ---------------- behavioural model: timing windows relative to acceptance ----------
   bit         m_on = 0, m_seq = 0, m_proto = 0, m_ov_prev = 0;
   int         m_E = 0, m_R = -100, m_ready_from = 0, m_pass = 0, m_fail = 0;
   logic       m_rpass = 0, m_rto = 0;
   logic [6:0] m_rscore = '0;
   logic [2:0] m_col[36];
   logic [2:0] m_srow[4], m_scol[4], m_arow[10], m_acol[10];
   logic       m_stype[4];
   logic [1:0] m_act[10];
   logic [6:0] m_exp;
   int         p, i_ld, j_ac, w_st, a_st;
   logic [13:0] exp_cc;
   logic [5:0]  exp_pos;

   always @(negedge clk) begin
      p    = cyc;
      a_st = m_E + 36 + GAP_CYC;
      w_st = a_st + 10;
      if (m_on) begin
         exp_cc = '0;
         if (m_seq && p >= m_E && p <= m_E + 35) begin
            i_ld    = p - m_E;
            exp_pos = (i_ld < 4) ? {m_srow[i_ld], m_scol[i_ld]} : 6'd0;
            exp_cc  = {1'b1, 1'b0, m_col[i_ld], exp_pos, (i_ld < 4) ? m_stype[i_ld] : 1'b0, 2'b00};
         end else if (m_seq && p >= a_st && p <= a_st + 9) begin
            j_ac   = p - a_st;
            exp_cc = {1'b0, 1'b1, 3'd0, m_arow[j_ac], m_acol[j_ac], 1'b0, m_act[j_ac]};
         end
         check("cc_inputs", 32'({in_valid_1, in_valid_2, in_color, in_starting_pos, in_stripe, in_action}),
               32'(exp_cc));
         check("pat_ready", 32'(pat_ready), 32'(!m_seq && p >= m_ready_from));
         check("res_valid", 32'(res_valid), 32'(p == m_R));
         check("res_fields", 32'({res_pass, res_timeout, res_score}), 32'({m_rpass, m_rto, m_rscore}));
         check("counts", 32'({pass_cnt, fail_cnt}), 32'({8'(m_pass), 8'(m_fail)}));
         check("proto_err", 32'(proto_err), 32'(m_proto));
      end
      // Inputs visible now are the ones sampled on the coming edge.
      if (!rst_n) begin
         m_on = 1; m_seq = 0; m_R = -100; m_ready_from = p + 1;
         m_pass = 0; m_fail = 0; m_proto = 0; m_ov_prev = 0;
         m_rpass = 0; m_rto = 0; m_rscore = '0;
      end else if (m_on) begin
         if (out_valid && m_seq && p >= m_E && p < w_st) m_proto = 1;
         if (out_valid && p >= m_R + 1 && p <= m_R + COOL_CYC) m_proto = 1;
         if (out_valid && m_ov_prev) m_proto = 1;
         if (!out_valid && out_score != 7'd0) m_proto = 1;
         if (m_seq && p >= w_st && (out_valid || p == w_st + TIMEOUT - 1)) begin
            m_R          = p + 1;
            m_seq        = 0;
            m_ready_from = m_R + COOL_CYC + 1;
            m_rto        = !out_valid;
            m_rscore     = out_valid ? out_score : 7'd0;
            m_rpass      = out_valid && (out_score == m_exp);
            if (m_rpass) m_pass = (m_pass < 255) ? m_pass + 1 : 255;
            else         m_fail = (m_fail < 255) ? m_fail + 1 : 255;
         end else if (!m_seq && pat_valid && p >= m_ready_from) begin
            m_seq  = 1;
            m_E    = p + 1;
            m_col  = s_col;  m_srow = s_srow; m_scol = s_scol; m_stype = s_stype;
            m_arow = s_arow; m_acol = s_acol; m_act  = s_act;  m_exp   = s_exp;
         end
         m_ov_prev = out_valid;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic set_ser(input logic [6:0] exp_score);
      for (int i = 0; i < 36; i++) s_col[i] = 3'(i % 6);
      s_srow = '{3'd1, 3'd3, 3'd5, 3'd0};
      s_scol = '{3'd2, 3'd4, 3'd0, 3'd5};
      s_stype = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int j = 0; j < 10; j++) begin
         s_arow[j] = 3'(j % 6);
         s_acol[j] = 3'((j + 3) % 8);
         s_act[j]  = 2'(j % 4);
      end
      s_exp = exp_score;
   endtask

   task automatic set_rand();
      for (int i = 0; i < 36; i++) s_col[i] = 3'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) begin
         s_srow[i]  = 3'($urandom_range(0, 7));
         s_scol[i]  = 3'($urandom_range(0, 7));
         s_stype[i] = 1'($urandom_range(0, 1));
      end
      for (int j = 0; j < 10; j++) begin
         s_arow[j] = 3'($urandom_range(0, 7));
         s_acol[j] = 3'($urandom_range(0, 7));
         s_act[j]  = 2'($urandom_range(0, 3));
      end
      s_exp = 7'($urandom_range(0, 127));
   endtask

   // mode: 0 normal, 1 literal serialisation checks, 2 out_valid pulse in LOAD,
   //       3 reset in ACT, 4 timeout
   task automatic send(input int d, input logic [6:0] score, input bit hold2, input int mode);
      int n = 0;
      int e, wst;
      while (pat_ready !== 1'b1 && n < 1000) begin
         step();
         n++;
      end
      if (n >= 1000) check("ready_wait", 32'(pat_ready), 32'd1);
      pat_data  = pack();
      pat_valid = 1'b1;
      step();
      pat_valid = 1'b0;
      e   = cyc;
      wst = e + 46 + GAP_CYC;
      if (mode == 1) begin
         while (cyc <= e + 36 + GAP_CYC) begin
            case (cyc - e)
               0:  check("ser_l0",  32'({in_valid_1, in_color, in_starting_pos, in_stripe}), 32'({1'b1, 3'd0, 6'o12, 1'b1}));
               1:  check("ser_l1",  32'({in_valid_1, in_color, in_starting_pos, in_stripe}), 32'({1'b1, 3'd1, 6'o34, 1'b0}));
               2:  check("ser_l2",  32'({in_valid_1, in_color, in_starting_pos, in_stripe}), 32'({1'b1, 3'd2, 6'o50, 1'b1}));
               3:  check("ser_l3",  32'({in_valid_1, in_color, in_starting_pos, in_stripe}), 32'({1'b1, 3'd3, 6'o05, 1'b0}));
               4:  check("ser_l4",  32'({in_valid_1, in_color, in_starting_pos, in_stripe}), 32'({1'b1, 3'd4, 6'o00, 1'b0}));
               35: check("ser_l35", 32'({in_valid_1, in_color, in_starting_pos, in_stripe}), 32'({1'b1, 3'd5, 6'o00, 1'b0}));
               36: check("ser_gap0", 32'({in_valid_1, in_valid_2}), 32'b00);
               36 + GAP_CYC - 1: check("ser_gapN", 32'({in_valid_1, in_valid_2}), 32'b00);
               36 + GAP_CYC: check("ser_act0", 32'({in_valid_2, in_starting_pos, in_action, in_color}),
                                   32'({1'b1, 3'd0, 3'd3, 2'd0, 3'd0}));
               default: ;
            endcase
            step();
         end
      end
      if (mode == 2) begin
         while (cyc < e + 3) step();
         out_valid = 1'b1;
         step();
         out_valid = 1'b0;
      end
      if (mode == 3) begin
         while (cyc < e + 36 + GAP_CYC + 4) step();
         rst_n = 1'b0;
         step();
         rst_n = 1'b1;
         check("rst_act_cc", 32'({in_valid_1, in_valid_2, in_color, in_starting_pos, in_stripe, in_action}), 32'd0);
         check("rst_act_res", 32'({res_valid, res_pass, res_timeout, res_score, proto_err}), 32'd0);
         check("rst_act_cnt", 32'({pass_cnt, fail_cnt}), 32'd0);
         check("rst_act_rdy", 32'(pat_ready), 32'd1);
         return;
      end
      if (mode == 4) begin
         while (cyc < wst + TIMEOUT - 1) step();
         check("to_early", 32'(res_valid), 32'd0);
         step();
         check("to_result", 32'({res_valid, res_timeout, res_pass, res_score, fail_cnt}),
               32'({1'b1, 1'b1, 1'b0, 7'd0, 8'd1}));
         return;
      end
      while (cyc < wst + d) step();
      out_valid = 1'b1;
      out_score = score;
      step();
      if (hold2) step();
      out_valid = 1'b0;
      out_score = '0;
   endtask

   initial begin
      repeat (3) step();
      rst_n = 1'b1;
      check("reset_state", 32'({pat_ready, in_valid_1, in_valid_2, res_valid, pass_cnt, fail_cnt, proto_err}),
            32'({1'b1, 3'b000, 16'd0, 1'b0}));

      // Serialisation and a passing result five cycles into WAIT.
      set_ser(7'd42);
      send(5, 7'd42, 1'b0, 1);
      check("pass_result", 32'({res_valid, res_pass, res_timeout, res_score, pass_cnt}),
            32'({1'b1, 1'b1, 1'b0, 7'd42, 8'd1}));

      // Score mismatch.
      set_rand();
      s_exp = 7'd42;
      send(3, 7'd41, 1'b0, 0);
      check("mismatch", 32'({res_valid, res_pass, res_timeout, res_score, fail_cnt}),
            32'({1'b1, 1'b0, 1'b0, 7'd41, 8'd1}));
      repeat (6) step();
      check("mismatch_hold", 32'({res_pass, res_score}), 32'({1'b0, 7'd41}));

      // Timeout from fresh counters.
      do_reset();
      set_ser(7'd10);
      send(0, 7'd0, 1'b0, 4);

      // out_valid held two cycles: protocol error, one result only.
      set_rand();
      send(0, s_exp, 1'b1, 0);
      check("hold2_proto", 32'(proto_err), 32'd1);
      repeat (8) step();
      check("hold2_once", 32'({pass_cnt, fail_cnt}), 32'({8'd1, 8'd1}));

      // Non-zero score without out_valid.
      do_reset();
      out_score = 7'd3;
      step();
      out_score = 7'd0;
      step();
      check("score_idle_proto", 32'(proto_err), 32'd1);

      // out_valid during LOAD flags an error but sequencing carries on.
      do_reset();
      set_rand();
      send(2, s_exp, 1'b0, 2);
      check("load_ov", 32'({proto_err, res_valid, res_pass}), 32'b111);

      // Reset during the action burst.
      set_rand();
      send(0, 7'd0, 1'b0, 3);

      // Back-to-back passing patterns until the pass counter saturates.
      for (int k = 0; k < 300; k++) begin
         set_rand();
         send(0, s_exp, 1'b0, 0);
      end
      repeat (6) step();
      check("pass_saturate", 32'({pass_cnt, fail_cnt, proto_err}), 32'({8'd255, 8'd0, 1'b0}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cc_pattern_driver.md
# cc_pattern_driver

Synthesizable stimulus sequencer and score checker placed directly upstream of the CC candy-crush core. It accepts one packed 223-bit pattern record per handshake and serializes it into CC's input protocol: a 36-cycle board load, then a 10-cycle action burst. It then waits for CC's single-cycle `out_valid`, compares `out_score` against the expected score in the record, and keeps running pass/fail counts. It also flags CC protocol violations.

## Interface
- `GAP_CYC`, 2: idle cycles between the last `in_valid_1` cycle and the first `in_valid_2` cycle (legal range 1–15).
- `TIMEOUT`, 500: maximum wait cycles for `out_valid` after the action burst.
- `COOL_CYC`, 3: idle cycles after each result before `pat_ready` reasserts.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pat_valid`  in  1  pattern word offered.
- `pat_ready`  out  1  driver can accept a pattern.
- `pat_data`  in  223  packed record:
  - [222:115] colours, 36×3, cell 0 in the MSBs.
  - [114:103] stripe rows, 4×3.
  - [102:91] stripe columns, 4×3.
  - [90:87] stripe types, 4×1, entry 0 at bit 90.
  - [86:57] action rows, 10×3.
  - [56:27] action columns, 10×3.
  - [26:7] actions, 10×2.
  - [6:0] expected score.
- `in_valid_1`, `in_valid_2`  out  1  CC load and action strobes.
- `in_color`  out  3  cell colour.
- `in_starting_pos`  out  6  {row, col}.
- `in_stripe`  out  1  stripe type.
- `in_action`  out  2  move direction.
- `out_valid`  in  1  CC result strobe.
- `out_score`  in  7  CC score.
- `res_valid`  out  1  one-cycle result pulse.
- `res_pass`  out  1  score matched and no timeout.
- `res_timeout`  out  1  no `out_valid` seen within `TIMEOUT` cycles.
- `res_score`  out  7  captured `out_score`; 0 on timeout.
- `pass_cnt`, `fail_cnt`  out  8  saturating counts of results.
- `proto_err`  out  1  sticky CC protocol violation.

## Operation
- All outputs are registered. Every output resets to 0, except `pat_ready`, which resets to 1.
- Reset takes effect mid-operation as well. It aborts any sequence, clears both counters and `proto_err`, and returns the FSM to IDLE.
- **IDLE**:
  - `pat_ready`=1.
  - When `pat_valid`&&`pat_ready`, latch `pat_data` into an internal register, drop `pat_ready`, and go to LOAD.
- **LOAD** (36 cycles, index i = 0..35):
  - `in_valid_1`=1.
  - `in_color`=colour[i].
  - For i<4: `in_starting_pos`={stripe_row[i], stripe_col[i]} and `in_stripe`=stripe_type[i].
  - For i≥4: `in_starting_pos`=0 and `in_stripe`=0.
- **GAP** (`GAP_CYC` cycles): all CC inputs are 0.
- **ACT** (10 cycles, j = 0..9):
  - `in_valid_2`=1.
  - `in_starting_pos`={act_row[j], act_col[j]}.
  - `in_action`=action[j].
  - `in_color`=0 and `in_stripe`=0.
- **WAIT**:
  - A 10-bit counter starts at 0 on the first WAIT cycle.
  - On `out_valid`=1, capture `out_score` and go to DONE.
  - If the counter reaches `TIMEOUT`-1 with no `out_valid`, go to DONE with the timeout flag set.
- **DONE** (1 cycle):
  - `res_valid`=1.
  - `res_pass`=(captured score == expected) && !timeout.
  - Increment `pass_cnt` or `fail_cnt`; each saturates at 255.
  - Then go to COOL.
- **COOL** (`COOL_CYC` cycles): then return to IDLE.
- `res_pass`, `res_timeout` and `res_score` hold their values until the next DONE.
- `proto_err` is set, and stays set until reset, on any of these:
  - `out_valid`=1 in LOAD, GAP or ACT.
  - `out_valid`=1 on two consecutive cycles.
  - `out_score`≠0 on a cycle where `out_valid`=0.
- `proto_err` does not alter sequencing.
- A second `out_valid` arriving in COOL sets `proto_err` only; it does not produce a second result.
- `pat_valid` outside IDLE is ignored; no data is latched.

## Timing
- Handshake accepted at edge T:
  - `in_valid_1` is high for cycles T+1 through T+36.
  - `in_valid_2` is high for cycles T+37+`GAP_CYC` through T+46+`GAP_CYC`.
- `out_valid` seen at edge W → `res_valid` high in cycle W+1.
- With `out_valid` absent, `res_valid` occurs exactly `TIMEOUT` cycles after the first WAIT cycle.
- `pat_ready` rises in cycle `COOL_CYC`+1 after `res_valid`.
- If `out_valid` arrives on the first WAIT cycle, it is accepted (zero-latency CC is legal).
- Reset asserted on any edge → the next cycle shows all reset values.

## Test plan
- **Serialization:** colour[i]=i%6, stripe entries {row,col}=(1,2),(3,4),(5,0),(0,5), types 1,0,1,0 → cycle-exact `in_color`, `in_starting_pos` and `in_stripe` sequence; `in_starting_pos`=0 from load cycle 4 onward; `in_valid_2` starts exactly `GAP_CYC`+1 cycles after the last `in_valid_1`.
- **Pass:** expected score 7'd42, model returns `out_score`=42 with `out_valid` 5 cycles into WAIT → `res_valid` next cycle, `res_pass`=1, `res_score`=42, `pass_cnt`=1.
- **Mismatch:** expected 42, `out_score`=41 → `res_pass`=0, `res_timeout`=0, `fail_cnt`=1.
- **Timeout:** `out_valid` never asserted → `res_valid` 500 cycles after WAIT entry, `res_timeout`=1, `res_score`=0, `fail_cnt`=1.
- **Protocol:** `out_valid` held for 2 cycles → `proto_err`=1 and only one result. Separately, `out_score`=3 while `out_valid`=0 → `proto_err`=1.
- **Reset mid-ACT, then back-to-back:** reset during the ACT burst → all outputs 0 and `pat_ready`=1 in the next cycle, counters 0. Then 300 back-to-back passing patterns → `pass_cnt` saturates at 255.
